// File: rtl/sha256_round_engine.sv
// SHA-256 compression rounds for a two-block job: 64 rounds per block, chaining via i_h_in.
// Latency: 130 edges from accepted start to FIN2 with no stalls. Backpressure: a round advances only on i_w_valid & o_w_ready.
// Optional build macro SHA_ABORT_EN adds i_abort, which returns any active job to IDLE.
module sha256_round_engine (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
`ifdef SHA_ABORT_EN
  input  logic         i_abort,
`endif
  input  logic         i_w_valid,
  input  logic [31:0]  i_w_data,
  output logic         o_w_ready,
  input  logic [255:0] i_h_in,
  output logic [1:0]   o_block,
  output logic [5:0]   o_round,
  output logic [255:0] o_work,
  output logic [31:0]  o_e,
  output logic         o_busy,
  output logic         o_done
);

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    S_IDLE, S_RUN1, S_FIN1, S_INIT2, S_RUN2, S_FIN2
  } state_t;

  state_t       r_state;
  logic [1:0]   r_block;
  logic [5:0]   r_round;
  logic [255:0] r_work;
  logic         r_busy;
  logic         r_done;
  logic         r_w_ready;

  logic [31:0]  w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [31:0]  w_k, w_s0, w_s1, w_ch, w_maj, w_t1, w_t2;
  logic [255:0] w_next;

  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = r_work;

  assign w_s1  = {w_e[5:0], w_e[31:6]} ^ {w_e[10:0], w_e[31:11]} ^ {w_e[24:0], w_e[31:25]};
  assign w_ch  = (w_e & w_f) ^ (~w_e & w_g);
  assign w_s0  = {w_a[1:0], w_a[31:2]} ^ {w_a[12:0], w_a[31:13]} ^ {w_a[21:0], w_a[31:22]};
  assign w_maj = (w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c);
  assign w_t1  = w_h + w_s1 + w_ch + w_k + i_w_data;
  assign w_t2  = w_s0 + w_maj;
  assign w_next = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

  // Round constants K[t]
  always_comb begin
    w_k = 32'h0;
    case (r_round)
      6'd0:  w_k = 32'h428a2f98;  6'd1:  w_k = 32'h71374491;  6'd2:  w_k = 32'hb5c0fbcf;  6'd3:  w_k = 32'he9b5dba5;
      6'd4:  w_k = 32'h3956c25b;  6'd5:  w_k = 32'h59f111f1;  6'd6:  w_k = 32'h923f82a4;  6'd7:  w_k = 32'hab1c5ed5;
      6'd8:  w_k = 32'hd807aa98;  6'd9:  w_k = 32'h12835b01;  6'd10: w_k = 32'h243185be;  6'd11: w_k = 32'h550c7dc3;
      6'd12: w_k = 32'h72be5d74;  6'd13: w_k = 32'h80deb1fe;  6'd14: w_k = 32'h9bdc06a7;  6'd15: w_k = 32'hc19bf174;
      6'd16: w_k = 32'he49b69c1;  6'd17: w_k = 32'hefbe4786;  6'd18: w_k = 32'h0fc19dc6;  6'd19: w_k = 32'h240ca1cc;
      6'd20: w_k = 32'h2de92c6f;  6'd21: w_k = 32'h4a7484aa;  6'd22: w_k = 32'h5cb0a9dc;  6'd23: w_k = 32'h76f988da;
      6'd24: w_k = 32'h983e5152;  6'd25: w_k = 32'ha831c66d;  6'd26: w_k = 32'hb00327c8;  6'd27: w_k = 32'hbf597fc7;
      6'd28: w_k = 32'hc6e00bf3;  6'd29: w_k = 32'hd5a79147;  6'd30: w_k = 32'h06ca6351;  6'd31: w_k = 32'h14292967;
      6'd32: w_k = 32'h27b70a85;  6'd33: w_k = 32'h2e1b2138;  6'd34: w_k = 32'h4d2c6dfc;  6'd35: w_k = 32'h53380d13;
      6'd36: w_k = 32'h650a7354;  6'd37: w_k = 32'h766a0abb;  6'd38: w_k = 32'h81c2c92e;  6'd39: w_k = 32'h92722c85;
      6'd40: w_k = 32'ha2bfe8a1;  6'd41: w_k = 32'ha81a664b;  6'd42: w_k = 32'hc24b8b70;  6'd43: w_k = 32'hc76c51a3;
      6'd44: w_k = 32'hd192e819;  6'd45: w_k = 32'hd6990624;  6'd46: w_k = 32'hf40e3585;  6'd47: w_k = 32'h106aa070;
      6'd48: w_k = 32'h19a4c116;  6'd49: w_k = 32'h1e376c08;  6'd50: w_k = 32'h2748774c;  6'd51: w_k = 32'h34b0bcb5;
      6'd52: w_k = 32'h391c0cb3;  6'd53: w_k = 32'h4ed8aa4a;  6'd54: w_k = 32'h5b9cca4f;  6'd55: w_k = 32'h682e6ff3;
      6'd56: w_k = 32'h748f82ee;  6'd57: w_k = 32'h78a5636f;  6'd58: w_k = 32'h84c87814;  6'd59: w_k = 32'h8cc70208;
      6'd60: w_k = 32'h90befffa;  6'd61: w_k = 32'ha4506ceb;  6'd62: w_k = 32'hbef9a3f7;  6'd63: w_k = 32'hc67178f2;
      default: w_k = 32'h0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_block   <= 2'd0;
      r_round   <= 6'd0;
      r_work    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_w_ready <= 1'b0;
    end
`ifdef SHA_ABORT_EN
    else if (i_abort && (r_state != S_IDLE)) begin
      // Working variables are left as they were so the aborted state can be inspected.
      r_state   <= S_IDLE;
      r_block   <= 2'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_w_ready <= 1'b0;
    end
`endif
    else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_work    <= IV;
            r_block   <= 2'd0;
            r_round   <= 6'd0;
            r_busy    <= 1'b1;
            r_w_ready <= 1'b1;
            r_state   <= S_RUN1;
          end
        end
        S_RUN1, S_RUN2: begin
          if (i_w_valid) begin
            r_work  <= w_next;
            r_round <= r_round + 6'd1;
            if (r_round == 6'd63) begin
              r_w_ready <= 1'b0;
              r_done    <= 1'b1;
              if (r_state == S_RUN1) begin
                r_block <= 2'd1;
                r_state <= S_FIN1;
              end else begin
                r_block <= 2'd2;
                r_busy  <= 1'b0;
                r_state <= S_FIN2;
              end
            end
          end
        end
        S_FIN1: begin
          r_done  <= 1'b0;
          r_state <= S_INIT2;
        end
        S_INIT2: begin
          r_work    <= i_h_in;
          r_round   <= 6'd0;
          r_w_ready <= 1'b1;
          r_state   <= S_RUN2;
        end
        S_FIN2: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_w_ready = r_w_ready;
  assign o_block   = r_block;
  assign o_round   = r_round;
  assign o_work    = r_work;
  assign o_e       = r_work[127:96];
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine using the "abc" block and hand-derived expectations.
module tb_sha256_round_engine;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic         i_w_valid = 1'b0;
  logic [31:0]  i_w_data = 32'h0;
  logic [255:0] i_h_in = '0;
  logic         o_w_ready;
  logic [1:0]   o_block;
  logic [5:0]   o_round;
  logic [255:0] o_work;
  logic [31:0]  o_e;
  logic         o_busy;
  logic         o_done;
`ifdef SHA_ABORT_EN
  logic         i_abort = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] wabc [64];

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  // SHA-256("abc") digest minus IV, word by word
  localparam logic [255:0] ABC_FINAL = {
    32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
    32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894
  };

  sha256_round_engine dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
`ifdef SHA_ABORT_EN
    .i_abort   (i_abort),
`endif
    .i_w_valid (i_w_valid),
    .i_w_data  (i_w_data),
    .o_w_ready (o_w_ready),
    .i_h_in    (i_h_in),
    .o_block   (o_block),
    .o_round   (o_round),
    .o_work    (o_work),
    .o_e       (o_e),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_schedule();
    for (int t = 0; t < 64; t++) begin
      if (t == 0)       wabc[t] = 32'h61626380;
      else if (t < 15)  wabc[t] = 32'h0;
      else if (t == 15) wabc[t] = 32'h00000018;
      else wabc[t] = (rotr(wabc[t-2], 17) ^ rotr(wabc[t-2], 19) ^ (wabc[t-2] >> 10)) + wabc[t-7]
                   + (rotr(wabc[t-15], 7) ^ rotr(wabc[t-15], 18) ^ (wabc[t-15] >> 3)) + wabc[t-16];
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_start = 1'b0; i_w_valid = 1'b0;
    tick(); tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Feeds words [from, from+n); toggle=1 offers nothing on even-numbered edges.
  task automatic run_block(input int from, input int n, input bit toggle, input bit zero_w, output int edges);
    int idx;
    bit acc;
    idx = from;
    edges = 0;
    while (idx < from + n && edges < 4 * n + 8) begin
      i_w_valid = toggle ? edges[0] : 1'b1;
      i_w_data  = zero_w ? 32'h0 : wabc[idx];
      acc = i_w_valid && o_w_ready;
      tick();
      edges++;
      if (acc) idx++;
    end
    i_w_valid = 1'b0;
    n_checks++;
    if (idx != from + n) begin n_fail++; $display("FAIL run_block_bound: fed %0d words, required %0d", idx - from, n); end
  endtask

  task automatic test_reset();
    i_start = 1'b1;
    i_rst_n = 1'b0;
    tick(); tick();
    i_start = 1'b0;
    n_checks++; if (o_block !== 2'd0)   begin n_fail++; $display("FAIL rst_block: got %0d want 0", o_block); end
    n_checks++; if (o_work !== 256'h0)  begin n_fail++; $display("FAIL rst_work: got %h want 0", o_work); end
    n_checks++; if (o_round !== 6'd0)   begin n_fail++; $display("FAIL rst_round: got %0d want 0", o_round); end
    n_checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_w_ready !== 1'b0)
      begin n_fail++; $display("FAIL rst_flags: busy=%b done=%b w_ready=%b want 000", o_busy, o_done, o_w_ready); end
    i_rst_n = 1'b1;
    tick(); tick();
    n_checks++; if (o_busy !== 1'b0 || o_w_ready !== 1'b0)
      begin n_fail++; $display("FAIL idle_hold: busy=%b w_ready=%b want 00", o_busy, o_w_ready); end
  endtask

  task automatic test_block1_abc();
    int edges;
    do_reset();
    pulse_start();
    n_checks++; if (o_work !== IV)      begin n_fail++; $display("FAIL start_iv: got %h want %h", o_work, IV); end
    n_checks++; if (o_busy !== 1'b1 || o_w_ready !== 1'b1 || o_block !== 2'd0)
      begin n_fail++; $display("FAIL start_flags: busy=%b w_ready=%b block=%0d want 1 1 0", o_busy, o_w_ready, o_block); end
    run_block(0, 64, 1'b0, 1'b0, edges);
    n_checks++; if (edges != 64)        begin n_fail++; $display("FAIL abc_edges: got %0d want 64", edges); end
    n_checks++; if (o_work !== ABC_FINAL) begin n_fail++; $display("FAIL abc_work: got %h want %h", o_work, ABC_FINAL); end
    n_checks++; if (o_e !== 32'h5ef50f24) begin n_fail++; $display("FAIL abc_e: got %h want 5ef50f24", o_e); end
    n_checks++; if (o_block !== 2'd1 || o_done !== 1'b1 || o_busy !== 1'b1 || o_w_ready !== 1'b0)
      begin n_fail++; $display("FAIL fin1_flags: block=%0d done=%b busy=%b w_ready=%b want 1 1 1 0", o_block, o_done, o_busy, o_w_ready); end
    tick();
    n_checks++; if (o_done !== 1'b0 || o_block !== 2'd1)
      begin n_fail++; $display("FAIL init2_flags: done=%b block=%0d want 0 1", o_done, o_block); end
  endtask

  task automatic test_stall();
    int edges;
    do_reset();
    pulse_start();
    run_block(0, 64, 1'b1, 1'b0, edges);
    n_checks++; if (edges != 128)       begin n_fail++; $display("FAIL stall_edges: got %0d want 128", edges); end
    n_checks++; if (o_work !== ABC_FINAL) begin n_fail++; $display("FAIL stall_work: got %h want %h", o_work, ABC_FINAL); end
    n_checks++; if (o_block !== 2'd1 || o_done !== 1'b1)
      begin n_fail++; $display("FAIL stall_fin1: block=%0d done=%b want 1 1", o_block, o_done); end
  endtask

  task automatic test_block2();
    int edges;
    do_reset();
    pulse_start();
    run_block(0, 64, 1'b0, 1'b1, edges);
    i_h_in = {256{1'b1}};
    tick();
    n_checks++; if (o_w_ready !== 1'b0) begin n_fail++; $display("FAIL init2_ready: got %b want 0", o_w_ready); end
    tick();
    n_checks++; if (o_work !== {256{1'b1}} || o_round !== 6'd0)
      begin n_fail++; $display("FAIL run2_load: work=%h round=%0d want all ones, 0", o_work, o_round); end
    n_checks++; if (o_block !== 2'd1 || o_w_ready !== 1'b1)
      begin n_fail++; $display("FAIL run2_flags: block=%0d w_ready=%b want 1 1", o_block, o_w_ready); end
    run_block(0, 64, 1'b0, 1'b1, edges);
    n_checks++; if (edges + 2 != 66)    begin n_fail++; $display("FAIL fin2_latency: got %0d want 66", edges + 2); end
    n_checks++; if (o_block !== 2'd2 || o_busy !== 1'b0 || o_done !== 1'b1)
      begin n_fail++; $display("FAIL fin2_flags: block=%0d busy=%b done=%b want 2 0 1", o_block, o_busy, o_done); end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (o_block !== 2'd2 || o_done !== 1'b0 || o_busy !== 1'b0 || o_w_ready !== 1'b0)
      begin n_fail++; $display("FAIL idle_after_job: block=%0d done=%b busy=%b w_ready=%b want 2 0 0 0", o_block, o_done, o_busy, o_w_ready); end
    pulse_start();
    n_checks++; if (o_block !== 2'd0 || o_busy !== 1'b1)
      begin n_fail++; $display("FAIL restart: block=%0d busy=%b want 0 1", o_block, o_busy); end
  endtask

  task automatic test_start_while_busy();
    int edges;
    do_reset();
    pulse_start();
    run_block(0, 10, 1'b0, 1'b0, edges);
    n_checks++; if (o_round !== 6'd10)  begin n_fail++; $display("FAIL busy_round10: got %0d want 10", o_round); end
    i_start = 1'b1;
    run_block(10, 1, 1'b0, 1'b0, edges);
    i_start = 1'b0;
    n_checks++; if (o_round !== 6'd11 || o_block !== 2'd0 || o_busy !== 1'b1)
      begin n_fail++; $display("FAIL busy_ignore: round=%0d block=%0d busy=%b want 11 0 1", o_round, o_block, o_busy); end
    run_block(11, 53, 1'b0, 1'b0, edges);
    n_checks++; if (o_work !== ABC_FINAL || o_block !== 2'd1)
      begin n_fail++; $display("FAIL busy_result: work=%h block=%0d want %h 1", o_work, o_block, ABC_FINAL); end
  endtask

  task automatic test_reset_mid_job();
    int edges;
    do_reset();
    pulse_start();
    run_block(0, 64, 1'b0, 1'b1, edges);
    tick(); tick();
    run_block(0, 30, 1'b0, 1'b0, edges);
    n_checks++; if (o_round !== 6'd30)  begin n_fail++; $display("FAIL run2_round30: got %0d want 30", o_round); end
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    n_checks++; if (o_block !== 2'd0 || o_work !== 256'h0 || o_e !== 32'h0 || o_round !== 6'd0)
      begin n_fail++; $display("FAIL midrst_data: block=%0d work=%h e=%h round=%0d want zeros", o_block, o_work, o_e, o_round); end
    n_checks++; if (o_busy !== 1'b0 || o_w_ready !== 1'b0 || o_done !== 1'b0)
      begin n_fail++; $display("FAIL midrst_flags: busy=%b w_ready=%b done=%b want 000", o_busy, o_w_ready, o_done); end
  endtask

`ifdef SHA_ABORT_EN
  task automatic test_abort();
    int edges;
    do_reset();
    pulse_start();
    run_block(0, 64, 1'b0, 1'b1, edges);
    tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    n_checks++; if (o_block !== 2'd0 || o_busy !== 1'b0 || o_w_ready !== 1'b0 || o_done !== 1'b0)
      begin n_fail++; $display("FAIL abort_flags: block=%0d busy=%b w_ready=%b done=%b want 0 0 0 0", o_block, o_busy, o_w_ready, o_done); end
    pulse_start();
    run_block(0, 64, 1'b0, 1'b0, edges);
    n_checks++; if (o_work !== ABC_FINAL || o_block !== 2'd1)
      begin n_fail++; $display("FAIL abort_rerun: work=%h block=%0d want %h 1", o_work, o_block, ABC_FINAL); end
  endtask
`endif

  initial begin
    build_schedule();
    test_reset();
    test_block1_abc();
    test_stall();
    test_block2();
    test_start_while_busy();
    test_reset_mid_job();
`ifdef SHA_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
